bpu_pred_queue: RTL and testbench

Prediction checkpoint queue between IF1 and EX. Every branch predicted at IF1 is pushed together with its BHT, GHR and final prediction bits. When EX resolves the oldest branch, the entry is popped, compared with the real outcome, and replayed as a registered update bundle. That bundle drives the predictor update ports (`ex_pc`, `ex_answ_bht`, `ex_answ_ghr`, `branched`) and the front-end redirect on a mispredict.

---
 rtl/bpu_pkg.sv | 15 +
 rtl/bpu_pq_ram.sv | 25 ++
 rtl/bpu_pred_queue.sv | 104 ++++++++++
 tb/tb_bpu_pred_queue.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/bpu_pkg.sv
// Shared types and constants for the branch prediction checkpoint queue.
package bpu_pkg;

  localparam int          BPQ_DEPTH_DEFAULT = 8;
  localparam logic [31:0] PC_STEP           = 32'd4;

  typedef struct packed {
    logic [31:0] pc;
    logic        bht;
    logic        ghr;
    logic        answ;
    logic [31:0] target;
  } bpq_entry_t;

endpackage

// File: rtl/bpu_pq_ram.sv
// Checkpoint storage: DEPTH x bpq_entry_t, one synchronous write port, one async read port.
// Latency: write visible the cycle after wr_en; read is combinational; no backpressure.
module bpu_pq_ram
  import bpu_pkg::*;
#(
  parameter int DEPTH = BPQ_DEPTH_DEFAULT,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [PTR_W-1:0] wr_addr,
  input  bpq_entry_t       wr_dat,
  input  logic [PTR_W-1:0] rd_addr,
  output bpq_entry_t       rd_dat
);

  bpq_entry_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_dat;
  end

  assign rd_dat = mem[rd_addr];

endmodule

// File: rtl/bpu_pred_queue.sv
// IF1->EX prediction checkpoint queue; resolves oldest entry into a registered update/redirect bundle.
// Latency: update one cycle after ex_resolve; IF1 stalls on full, overflow/underflow set sticky err.
module bpu_pred_queue
  import bpu_pkg::*;
#(
  parameter int DEPTH = BPQ_DEPTH_DEFAULT,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             if1_push,
  input  logic [31:0]      if1_pc,
  input  logic             if1_answ_bht,
  input  logic             if1_answ_ghr,
  input  logic             if1_answ,
  input  logic [31:0]      if1_target,
  input  logic             ex_resolve,
  input  logic             ex_taken,
  input  logic [31:0]      ex_target,
  output logic             full,
  output logic             empty,
  output logic [PTR_W:0]   count,
  output logic             upd_valid,
  output logic [31:0]      upd_pc,
  output logic             upd_answ_bht,
  output logic             upd_answ_ghr,
  output logic             upd_branched,
  output logic             mispredict,
  output logic [31:0]      redirect_pc,
  output logic             err
);

  localparam logic [PTR_W:0]   DEPTH_C = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

  logic [PTR_W-1:0] head, tail;
  bpq_entry_t       wr_ent, rd_ent;
  logic             pop, mp, push_ok, push_err, resolve_err;
  logic [31:0]      redir;

  assign wr_ent = '{pc: if1_pc, bht: if1_answ_bht, ghr: if1_answ_ghr,
                    answ: if1_answ, target: if1_target};

  bpu_pq_ram #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_ram (
    .clk     (clk),
    .wr_en   (push_ok),
    .wr_addr (tail),
    .wr_dat  (wr_ent),
    .rd_addr (head),
    .rd_dat  (rd_ent)
  );

  assign full  = (count == DEPTH_C);
  assign empty = (count == '0);

  always_comb begin
    pop         = ex_resolve && !empty;
    resolve_err = ex_resolve && empty;
    mp          = pop && ((rd_ent.answ != ex_taken) ||
                          (ex_taken && rd_ent.answ && (rd_ent.target != ex_target)));
    // a push alongside a mispredict is wrong-path: silently dropped, not an error
    push_ok     = if1_push && !mp && (!full || pop);
    push_err    = if1_push && !mp && full && !pop;
    redir       = ex_taken ? ex_target : rd_ent.pc + PC_STEP;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head         <= '0;
      tail         <= '0;
      count        <= '0;
      err          <= 1'b0;
      upd_valid    <= 1'b0;
      mispredict   <= 1'b0;
      upd_pc       <= '0;
      upd_answ_bht <= 1'b0;
      upd_answ_ghr <= 1'b0;
      upd_branched <= 1'b0;
      redirect_pc  <= '0;
    end else begin
      upd_valid  <= pop;
      mispredict <= mp;
      if (pop) begin
        upd_pc       <= rd_ent.pc;
        upd_answ_bht <= rd_ent.bht;
        upd_answ_ghr <= rd_ent.ghr;
        upd_branched <= ex_taken;
        redirect_pc  <= redir;
      end
      if (push_err || resolve_err) err <= 1'b1;
      if (mp) begin
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end else begin
        if (push_ok) tail <= tail + PTR_ONE;
        if (pop)     head <= head + PTR_ONE;
        if (push_ok && !pop)      count <= count + 1'b1;
        else if (!push_ok && pop) count <= count - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_bpu_pred_queue.sv
// Scoreboard bench for bpu_pred_queue: directed pushes/resolves, expected updates queued and checked by a monitor.
module tb_bpu_pred_queue;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if1_push = 1'b0;
  logic [31:0] if1_pc = '0;
  logic        if1_answ_bht = 1'b0, if1_answ_ghr = 1'b0, if1_answ = 1'b0;
  logic [31:0] if1_target = '0;
  logic        ex_resolve = 1'b0, ex_taken = 1'b0;
  logic [31:0] ex_target = '0;
  logic        full, empty, upd_valid, upd_answ_bht, upd_answ_ghr, upd_branched, mispredict, err;
  logic [3:0]  count;
  logic [31:0] upd_pc, redirect_pc;

  int checks = 0;
  int errors = 0;
  logic mon_en = 1'b0;

  typedef struct {
    logic [31:0] pc;
    logic        bht, ghr, br, mp;
    logic [31:0] rpc;
  } exp_t;
  exp_t sb[$];

  bpu_pred_queue #(.DEPTH(8), .PTR_W(3)) dut (
    .clk(clk), .rst(rst),
    .if1_push(if1_push), .if1_pc(if1_pc), .if1_answ_bht(if1_answ_bht),
    .if1_answ_ghr(if1_answ_ghr), .if1_answ(if1_answ), .if1_target(if1_target),
    .ex_resolve(ex_resolve), .ex_taken(ex_taken), .ex_target(ex_target),
    .full(full), .empty(empty), .count(count),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_answ_bht(upd_answ_bht),
    .upd_answ_ghr(upd_answ_ghr), .upd_branched(upd_branched),
    .mispredict(mispredict), .redirect_pc(redirect_pc), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic expect_upd(input logic [31:0] pc, input logic bht, input logic ghr,
                            input logic br, input logic mp, input logic [31:0] rpc);
    exp_t e;
    e.pc = pc; e.bht = bht; e.ghr = ghr; e.br = br; e.mp = mp; e.rpc = rpc;
    sb.push_back(e);
  endtask

  // one cycle of stimulus; inputs change 1 time unit after the edge
  task automatic cyc(input logic p, input logic [31:0] pc, input logic bht, input logic ghr,
                     input logic answ, input logic [31:0] tgt,
                     input logic r, input logic tk, input logic [31:0] et);
    if1_push = p; if1_pc = pc; if1_answ_bht = bht; if1_answ_ghr = ghr;
    if1_answ = answ; if1_target = tgt;
    ex_resolve = r; ex_taken = tk; ex_target = et;
    @(posedge clk); #1;
    if1_push = 1'b0; ex_resolve = 1'b0;
  endtask

  task automatic idle();
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, '0);
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (mon_en) begin
      if (upd_valid === 1'b1) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_upd: upd_valid=1 with pc %h, expected no update", upd_pc);
        end else begin
          e = sb.pop_front();
          chk("upd_pc", upd_pc, e.pc);
          chk("upd_bht", upd_answ_bht, e.bht);
          chk("upd_ghr", upd_answ_ghr, e.ghr);
          chk("upd_branched", upd_branched, e.br);
          chk("mispredict", mispredict, e.mp);
          chk("redirect_pc", redirect_pc, e.rpc);
        end
      end else begin
        chk("mispredict_idle", mispredict, 1'b0);
      end
    end
  end

  function automatic logic [31:0] wpc(input int i);
    return 32'h1C001000 + 32'(i) * 32'd16;
  endfunction

  initial begin
    // reset and idle
    rst = 1'b1;
    idle(); idle();
    chk("rst_empty", empty, 1'b1);
    chk("rst_count", count, 0);
    chk("rst_full", full, 1'b0);
    chk("rst_upd_valid", upd_valid, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_upd_pc", upd_pc, 32'h0);
    chk("rst_redirect_pc", redirect_pc, 32'h0);
    rst = 1'b0;
    mon_en = 1'b1;
    idle(); idle();
    chk("idle_empty", empty, 1'b1);
    chk("idle_count", count, 0);
    chk("idle_err", err, 1'b0);

    // correct taken prediction
    cyc(1'b1, 32'h1C000100, 1'b1, 1'b0, 1'b1, 32'h1C000200, 1'b0, 1'b0, '0);
    chk("cp_count_push", count, 1);
    expect_upd(32'h1C000100, 1'b1, 1'b0, 1'b1, 1'b0, 32'h1C000200);
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b0, '0, 1'b1, 1'b1, 32'h1C000200);
    chk("cp_upd_valid", upd_valid, 1'b1);
    chk("cp_count_pop", count, 0);
    idle();

    // direction mispredict flushes younger entries and drops the concurrent push
    cyc(1'b1, 32'h1C000040, 1'b0, 1'b1, 1'b1, 32'h1C000080, 1'b0, 1'b0, '0);
    cyc(1'b1, 32'h1C000050, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, '0);
    cyc(1'b1, 32'h1C000060, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, '0);
    chk("dm_count3", count, 3);
    expect_upd(32'h1C000040, 1'b0, 1'b1, 1'b0, 1'b1, 32'h1C000044);
    cyc(1'b1, 32'h1C000070, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, '0);
    chk("dm_mispredict", mispredict, 1'b1);
    chk("dm_redirect", redirect_pc, 32'h1C000044);
    chk("dm_count", count, 0);
    chk("dm_empty", empty, 1'b1);
    chk("dm_err", err, 1'b0);
    idle();
    chk("dm_count_after", count, 0);

    // target mispredict
    cyc(1'b1, 32'h1C000200, 1'b1, 1'b1, 1'b1, 32'h1C000300, 1'b0, 1'b0, '0);
    expect_upd(32'h1C000200, 1'b1, 1'b1, 1'b1, 1'b1, 32'h1C000380);
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b0, '0, 1'b1, 1'b1, 32'h1C000380);
    chk("tm_count", count, 0);
    idle();

    // fill, overflow, then steady push+pop across pointer wrap
    for (int i = 0; i < 8; i++)
      cyc(1'b1, wpc(i), i[0], i[1], 1'b0, 32'h0, 1'b0, 1'b0, '0);
    chk("fw_full", full, 1'b1);
    chk("fw_count8", count, 8);
    chk("fw_err_before", err, 1'b0);
    cyc(1'b1, 32'hDEAD0000, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, '0);
    chk("fw_err_overflow", err, 1'b1);
    chk("fw_count_overflow", count, 8);
    for (int k = 0; k < 10; k++) begin
      expect_upd(wpc(k), k[0], k[1], 1'b0, 1'b0, wpc(k) + 32'd4);
      cyc(1'b1, wpc(k + 8), k[0] ^ 1'b0, k[1], 1'b0, 32'h0, 1'b1, 1'b0, '0);
      chk("fw_count_steady", count, 8);
    end

    // reset mid-operation with a pending resolve: nothing emitted
    rst = 1'b1;
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b0, '0, 1'b1, 1'b0, '0);
    chk("mr_upd_valid", upd_valid, 1'b0);
    chk("mr_count", count, 0);
    chk("mr_err", err, 1'b0);
    rst = 1'b0;
    idle();

    // resolve on empty with simultaneous push
    cyc(1'b1, 32'h1C002000, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, '0);
    chk("re_upd_valid", upd_valid, 1'b0);
    chk("re_err", err, 1'b1);
    chk("re_count", count, 1);
    expect_upd(32'h1C002000, 1'b0, 1'b1, 1'b0, 1'b0, 32'h1C002004);
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b0, '0, 1'b1, 1'b0, '0);
    chk("re_count_drain", count, 0);
    idle(); idle();

    chk("sb_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
